// File: rtl/vga_pkg.sv
// Shared definitions for the VGA text-window slice.
//   rgb9_t            : 9-bit colour {R[2:0],G[2:0],B[2:0]}
//   H_ACTIVE_DEFAULT  : visible pixels per line
//   V_ACTIVE_DEFAULT  : visible lines per frame
//   FRAME_START_*     : pixel/line coordinates that mark the start of a frame
//   isFrameStart()    : frame-start predicate on the timing-generator counters
package vga_pkg;

  typedef logic [8:0] rgb9_t;

  localparam int H_ACTIVE_DEFAULT = 640;
  localparam int V_ACTIVE_DEFAULT = 400;

  localparam logic [9:0] FRAME_START_PIXEL = 10'd0;
  localparam logic [8:0] FRAME_START_LINE  = 9'd0;

  localparam rgb9_t RGB_BLACK = 9'd0;

  function automatic logic isFrameStart(input logic [9:0] pixel, input logic [8:0] line);
    return (pixel == FRAME_START_PIXEL) && (line == FRAME_START_LINE);
  endfunction

endpackage

// File: rtl/vga_scale_counter.sv
// Cascaded sub/glyph/char position counter for one axis of the text window.
// The sub counter wraps at mag, the glyph counter at GLYPH_N-1 and the char
// counter saturates at CHARS_N-1, so the position holds on the last cell.
// Ports:
//   clock, reset : pixel clock, asynchronous active-high reset
//   start        : position of this step is the window origin (all zero)
//   advance      : take one step this cycle; outputs show the new position
//   mag          : magnification minus 1 (sub-pixel repeat count)
//   glyphCnt     : pixel/line index inside the glyph
//   charCnt      : character column/row index
// Outputs are the position of the current pixel/line: the stepped value while
// advance is high, otherwise the stored value.
module vga_scale_counter
  import vga_pkg::*;
#(
  parameter int GLYPH_N = 8,
  parameter int CHARS_N = 8,
  localparam int GW = $clog2(GLYPH_N),
  localparam int CW = $clog2(CHARS_N)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic          advance,
  input  logic [1:0]    mag,
  output logic [GW-1:0] glyphCnt,
  output logic [CW-1:0] charCnt
);

  localparam logic [GW-1:0] GLYPH_LAST = GW'(GLYPH_N - 1);
  localparam logic [CW-1:0] CHAR_LAST  = CW'(CHARS_N - 1);

  logic [1:0]    subR, subNext;
  logic [GW-1:0] glyphR, glyphNext;
  logic [CW-1:0] charR, charNext;

  // Next position: clear at the origin, otherwise cascade-increment and hold on the last cell
  always_comb begin
    subNext   = subR;
    glyphNext = glyphR;
    charNext  = charR;
    if (!advance) begin
      subNext   = subR;
    end else if (start) begin
      subNext   = 2'd0;
      glyphNext = '0;
      charNext  = '0;
    end else if (subR != mag) begin
      subNext   = subR + 2'd1;
    end else if (glyphR != GLYPH_LAST) begin
      subNext   = 2'd0;
      glyphNext = glyphR + GW'(1'b1);
    end else if (charR != CHAR_LAST) begin
      subNext   = 2'd0;
      glyphNext = '0;
      charNext  = charR + CW'(1'b1);
    end else begin
      subNext   = subR;
    end
  end

  assign glyphCnt = glyphNext;
  assign charCnt  = charNext;

  // Position state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      subR   <= 2'd0;
      glyphR <= '0;
      charR  <= '0;
    end else begin
      subR   <= subNext;
      glyphR <= glyphNext;
      charR  <= charNext;
    end
  end

endmodule

// File: rtl/vga_text_window.sv
// COLS x ROWS text window renderer with programmable origin and x1..x4
// magnification. Three-clock pipeline from pixelCnt/lineCnt to vgaRGB:
//   S0 registers hit/glyph position and the text-buffer address,
//   S1 registers the font address {charCode, glyphRow},
//   S2 selects the glyph bit and registers the output colour.
// Text buffer and font ROM are read asynchronously from the registered
// addresses, so their data is used in the cycle after the address is launched.
// Optional feature macro: VGA_TEXT_CURSOR_EN adds a blinking inverse cursor
// (ports cursorCol, cursorRow, cursorOn; blink phase is bit 5 of a frame counter).
// Ports:
//   clock, reset       : pixel clock, asynchronous active-high reset
//   pixelCnt, lineCnt  : current beam position from the timing generator
//   originX, originY   : window top-left corner (latched at frame start)
//   magnify            : scale minus 1 (latched at frame start)
//   fgRGB, bgRGB       : glyph foreground / in-window background colours
//   charAddr, charCode : text buffer address (row*COLS+col) and data
//   fontAddr, fontData : font ROM address {code,glyphRow} and row (MSB leftmost)
//   inWindow, vgaRGB   : registered window-hit flag and pixel colour
module vga_text_window
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEFAULT,
  parameter int V_ACTIVE = V_ACTIVE_DEFAULT,
  parameter int GLYPH_W  = 8,
  parameter int GLYPH_H  = 16,
  parameter int COLS     = 8,
  parameter int ROWS     = 2,
  localparam int AW  = $clog2(COLS * ROWS),
  localparam int GCW = $clog2(GLYPH_W),
  localparam int GRW = $clog2(GLYPH_H),
  localparam int CCW = $clog2(COLS),
  localparam int CRW = $clog2(ROWS)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [9:0]         pixelCnt,
  input  logic [8:0]         lineCnt,
  input  logic [9:0]         originX,
  input  logic [8:0]         originY,
  input  logic [1:0]         magnify,
  input  logic [8:0]         fgRGB,
  input  logic [8:0]         bgRGB,
`ifdef VGA_TEXT_CURSOR_EN
  input  logic [CCW-1:0]     cursorCol,
  input  logic [CRW-1:0]     cursorRow,
  input  logic               cursorOn,
`endif
  output logic [AW-1:0]      charAddr,
  input  logic [7:0]         charCode,
  output logic [8+GRW-1:0]   fontAddr,
  input  logic [GLYPH_W-1:0] fontData,
  output logic               inWindow,
  output logic [8:0]         vgaRGB
);

  localparam logic [AW-1:0]  COLS_A   = AW'(COLS);
  localparam logic [11:0]    CELL_W1  = 12'(COLS * GLYPH_W);
  localparam logic [11:0]    CELL_H1  = 12'(ROWS * GLYPH_H);
  localparam logic [GCW-1:0] BIT_LAST = GCW'(GLYPH_W - 1);

  logic       frameStart;
  logic [9:0] shadowX, effX;
  logic [8:0] shadowY, effY;
  logic [1:0] shadowMag, effMag;
  logic       armed, effArmed;

  logic [11:0] magPlus1, winW, winH, xEnd, yEnd, pix12, line12;
  logic        hitX, hitY, hitS;

  logic           hStart, vStart, vAdvance;
  logic [GCW-1:0] glyphCol;
  logic [GRW-1:0] glyphRow;
  logic [CCW-1:0] charCol;
  logic [CRW-1:0] charRow;
  logic [AW-1:0]  cellAddr;

  logic           hit0, hit1;
  logic [GCW-1:0] gCol0, gCol1;
  logic [GRW-1:0] gRow0;
  logic [GCW-1:0] bitIdx;
  logic           invertBit, pixBit;
  rgb9_t          nextRGB;

  assign frameStart = isFrameStart(pixelCnt, lineCnt);

  // Latch window geometry at frame start; mid-frame input changes wait for the next frame
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shadowX   <= 10'd0;
      shadowY   <= 9'd0;
      shadowMag <= 2'd0;
      armed     <= 1'b0;
    end else if (frameStart) begin
      shadowX   <= originX;
      shadowY   <= originY;
      shadowMag <= magnify;
      armed     <= 1'b1;
    end else begin
      shadowX   <= shadowX;
      shadowY   <= shadowY;
      shadowMag <= shadowMag;
      armed     <= armed;
    end
  end

  // The frame-start pixel already uses the values being latched on it
  always_comb begin
    if (frameStart) begin
      effX     = originX;
      effY     = originY;
      effMag   = magnify;
      effArmed = 1'b1;
    end else begin
      effX     = shadowX;
      effY     = shadowY;
      effMag   = shadowMag;
      effArmed = armed;
    end
  end

  // Window hit test in 12 bits so origin + size never wraps; clipped to the active area
  always_comb begin
    magPlus1 = {10'd0, effMag} + 12'd1;
    winW     = CELL_W1 * magPlus1;
    winH     = CELL_H1 * magPlus1;
    pix12    = {2'd0, pixelCnt};
    line12   = {3'd0, lineCnt};
    xEnd     = {2'd0, effX} + winW;
    yEnd     = {3'd0, effY} + winH;
    hitX     = (pix12 >= {2'd0, effX}) && (pix12 < xEnd) && (pix12 < 12'(H_ACTIVE));
    hitY     = (line12 >= {3'd0, effY}) && (line12 < yEnd) && (line12 < 12'(V_ACTIVE));
    hitS     = effArmed && hitX && hitY;
  end

  assign hStart   = (pixelCnt == effX);
  assign vStart   = (lineCnt == effY);
  assign vAdvance = (pixelCnt == 10'd0);

  vga_scale_counter #(.GLYPH_N(GLYPH_W), .CHARS_N(COLS)) hCount (
    .clock    (clock),
    .reset    (reset),
    .start    (hStart),
    .advance  (1'b1),
    .mag      (effMag),
    .glyphCnt (glyphCol),
    .charCnt  (charCol)
  );

  vga_scale_counter #(.GLYPH_N(GLYPH_H), .CHARS_N(ROWS)) vCount (
    .clock    (clock),
    .reset    (reset),
    .start    (vStart),
    .advance  (vAdvance),
    .mag      (effMag),
    .glyphCnt (glyphRow),
    .charCnt  (charRow)
  );

  assign cellAddr = AW'(charRow) * COLS_A + AW'(charCol);

`ifdef VGA_TEXT_CURSOR_EN
  logic [CCW-1:0] shadowCurCol, effCurCol;
  logic [CRW-1:0] shadowCurRow, effCurRow;
  logic           shadowCurOn, effCurOn;
  logic [5:0]     frameCnt, frameCntNext, effFrameCnt;
  logic           cursorS, cursor0, cursor1;

  assign frameCntNext = frameCnt + 6'd1;

  // Latch cursor at frame start; the first frame after reset counts as frame 0
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shadowCurCol <= '0;
      shadowCurRow <= '0;
      shadowCurOn  <= 1'b0;
      frameCnt     <= 6'd0;
    end else if (frameStart) begin
      shadowCurCol <= cursorCol;
      shadowCurRow <= cursorRow;
      shadowCurOn  <= cursorOn;
      frameCnt     <= armed ? frameCntNext : frameCnt;
    end else begin
      shadowCurCol <= shadowCurCol;
      shadowCurRow <= shadowCurRow;
      shadowCurOn  <= shadowCurOn;
      frameCnt     <= frameCnt;
    end
  end

  // Effective cursor state and cursor-cell detect for the current pixel
  always_comb begin
    if (frameStart) begin
      effCurCol   = cursorCol;
      effCurRow   = cursorRow;
      effCurOn    = cursorOn;
      effFrameCnt = armed ? frameCntNext : frameCnt;
    end else begin
      effCurCol   = shadowCurCol;
      effCurRow   = shadowCurRow;
      effCurOn    = shadowCurOn;
      effFrameCnt = frameCnt;
    end
    cursorS = effCurOn && effFrameCnt[5] && (charRow == effCurRow) && (charCol == effCurCol);
  end

  // Carry the cursor-cell flag alongside the hit flag
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cursor0 <= 1'b0;
      cursor1 <= 1'b0;
    end else begin
      cursor0 <= cursorS;
      cursor1 <= cursor0;
    end
  end

  assign invertBit = cursor1;
`else
  assign invertBit = 1'b0;
`endif

  assign bitIdx = BIT_LAST - gCol1;
  assign pixBit = fontData[bitIdx] ^ invertBit;

  // Output colour: glyph bit selects fg/bg inside the window, black outside
  always_comb begin
    if (hit1) begin
      if (pixBit) begin
        nextRGB = fgRGB;
      end else begin
        nextRGB = bgRGB;
      end
    end else begin
      nextRGB = RGB_BLACK;
    end
  end

  // Three-stage fetch pipeline and output register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hit0     <= 1'b0;
      gCol0    <= '0;
      gRow0    <= '0;
      charAddr <= '0;
      hit1     <= 1'b0;
      gCol1    <= '0;
      fontAddr <= '0;
      inWindow <= 1'b0;
      vgaRGB   <= RGB_BLACK;
    end else begin
      hit0     <= hitS;
      gCol0    <= glyphCol;
      gRow0    <= glyphRow;
      charAddr <= cellAddr;
      hit1     <= hit0;
      gCol1    <= gCol0;
      fontAddr <= {charCode, gRow0};
      inWindow <= hit1;
      vgaRGB   <= nextRGB;
    end
  end

endmodule

// File: tb/tb_vga_text_window.sv
// Self-checking bench for vga_text_window. Pixels are streamed frame by frame
// (only the lines/pixels around the window are visited, always consecutively
// across it); every output is compared with a reference model that derives
// cell, glyph row and glyph column by division from the latched frame origin.
module tb_vga_text_window;

  logic       clock;
  logic       reset;
  logic [9:0] pixelCnt;
  logic [8:0] lineCnt;
  logic [9:0] originX;
  logic [8:0] originY;
  logic [1:0] magnify;
  logic [8:0] fgRGB;
  logic [8:0] bgRGB;
  logic [3:0] charAddr;
  logic [7:0] charCode;
  logic [11:0] fontAddr;
  logic [7:0] fontData;
  logic       inWindow;
  logic [8:0] vgaRGB;
`ifdef VGA_TEXT_CURSOR_EN
  logic [2:0] cursorCol;
  logic [0:0] cursorRow;
  logic       cursorOn;
  initial begin
    cursorCol = 3'd0;
    cursorRow = 1'b0;
    cursorOn  = 1'b0;
  end
`endif

  logic [7:0] textBuf [0:15];
  logic [7:0] fontRom [0:4095];

  assign charCode = textBuf[charAddr];
  assign fontData = fontRom[fontAddr];

  vga_text_window dut (
    .clock    (clock),
    .reset    (reset),
    .pixelCnt (pixelCnt),
    .lineCnt  (lineCnt),
    .originX  (originX),
    .originY  (originY),
    .magnify  (magnify),
    .fgRGB    (fgRGB),
    .bgRGB    (bgRGB),
`ifdef VGA_TEXT_CURSOR_EN
    .cursorCol(cursorCol),
    .cursorRow(cursorRow),
    .cursorOn (cursorOn),
`endif
    .charAddr (charAddr),
    .charCode (charCode),
    .fontAddr (fontAddr),
    .fontData (fontData),
    .inWindow (inWindow),
    .vgaRGB   (vgaRGB)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  // model state: latched frame geometry
  logic mArmed = 1'b0;
  int   mX = 0, mY = 0, mMag = 0;
  int   resetLine = -1, releaseLine = -1;

  // expected {inWindow, rgb} of pixels still inside the pipeline
  logic [9:0] pipeExp [0:2];
  int         pipeX [0:2];
  int         pipeY [0:2];

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [9:0] modelPixel(input int x, input int y);
    int s, w, h, dx, dy, gc, cc, gr, cr, code;
    logic [7:0] row;
    s = mMag + 1;
    w = 64 * s;
    h = 32 * s;
    if (!mArmed) return 10'd0;
    if (x < mX || x >= mX + w || x >= 640) return 10'd0;
    if (y < mY || y >= mY + h || y >= 400) return 10'd0;
    dx = x - mX;
    dy = y - mY;
    gc = (dx / s) % 8;
    cc = dx / (8 * s);
    gr = (dy / s) % 16;
    cr = dy / (16 * s);
    code = int'(textBuf[cr * 8 + cc]);
    row = fontRom[code * 16 + gr];
    return {1'b1, row[7 - gc] ? fgRGB : bgRGB};
  endfunction

  // one pixel clock: check output of the pixel 3 cycles back, then drive a new one
  task automatic stepPixel(input int x, input int y);
    @(negedge clock);
    checkVal($sformatf("inWindow(%0d,%0d)", pipeX[2], pipeY[2]), {31'd0, inWindow}, {31'd0, pipeExp[2][9]});
    checkVal($sformatf("vgaRGB(%0d,%0d)", pipeX[2], pipeY[2]), {23'd0, vgaRGB}, {23'd0, pipeExp[2][8:0]});
    for (int i = 2; i > 0; i--) begin
      pipeExp[i] = pipeExp[i-1];
      pipeX[i] = pipeX[i-1];
      pipeY[i] = pipeY[i-1];
    end
    if (x == 0 && y == resetLine) begin
      reset = 1'b1;
      mArmed = 1'b0;
      for (int i = 0; i < 3; i++) pipeExp[i] = 10'd0;
    end
    if (x == 0 && y == releaseLine) reset = 1'b0;
    pixelCnt = x[9:0];
    lineCnt = y[8:0];
    if (x == 0 && y == 0 && !reset) begin
      mX = int'(originX);
      mY = int'(originY);
      mMag = int'(magnify);
      mArmed = 1'b1;
    end
    pipeExp[0] = reset ? 10'd0 : modelPixel(x, y);
    pipeX[0] = x;
    pipeY[0] = y;
  endtask

  task automatic runLine(input int y, input int fx, input int w);
    int lo, hi;
    lo = (fx - 2 > 1) ? fx - 2 : 1;
    hi = (fx + w + 2 < 642) ? fx + w + 2 : 642;
    stepPixel(0, y);
    for (int x = lo; x <= hi; x++) stepPixel(x, y);
    for (int x = 700; x < 703; x++) stepPixel(x, y);
  endtask

  task automatic runFrame(input int midLine, input logic [9:0] newX);
    int fx, fy, s, w, h, lo, hi;
    fx = int'(originX);
    fy = int'(originY);
    s = int'(magnify) + 1;
    w = 64 * s;
    h = 32 * s;
    runLine(0, fx, w);
    lo = (fy - 1 > 1) ? fy - 1 : 1;
    hi = (fy + h + 1 < 401) ? fy + h + 1 : 401;
    for (int y = lo; y <= hi; y++) begin
      if (y == midLine) originX = newX;
      runLine(y, fx, w);
    end
  endtask

  task automatic setFrame(input int x, input int y, input int m);
    originX = x[9:0];
    originY = y[8:0];
    magnify = m[1:0];
    fgRGB = 9'($urandom_range(0, 511));
    bgRGB = 9'($urandom_range(0, 511));
    if (bgRGB == fgRGB) bgRGB = ~fgRGB;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) textBuf[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 4096; i++) fontRom[i] = 8'($urandom_range(0, 255));
    textBuf[0] = 8'h41;
    fontRom[16'h41 * 16] = 8'b1000_0001;
    for (int i = 0; i < 3; i++) begin
      pipeExp[i] = 10'd0;
      pipeX[i] = 0;
      pipeY[i] = 0;
    end

    reset = 1'b1;
    pixelCnt = 10'd700;
    lineCnt = 9'd450;
    setFrame(100, 50, 0);
    repeat (3) @(negedge clock);
    checkVal("reset vgaRGB", {23'd0, vgaRGB}, 32'd0);
    checkVal("reset inWindow", {31'd0, inWindow}, 32'd0);
    checkVal("reset charAddr", {28'd0, charAddr}, 32'd0);
    checkVal("reset fontAddr", {20'd0, fontAddr}, 32'd0);
    reset = 1'b0;

    // not armed yet: window pixels stay black
    for (int x = 95; x < 170; x++) stepPixel(x, 50);

    setFrame(100, 50, 0);
    runFrame(-1, 10'd0);
    setFrame(100, 50, 1);
    runFrame(-1, 10'd0);
    setFrame(600, 390, 3);
    runFrame(-1, 10'd0);
    // mid-frame origin change applies only from the next frame
    setFrame(100, 50, 0);
    runFrame(60, 10'd200);
    runFrame(-1, 10'd0);
    // reset inside the window, output stays black until the next frame start
    resetLine = 60;
    releaseLine = 70;
    runFrame(-1, 10'd0);
    resetLine = -1;
    releaseLine = -1;
    runFrame(-1, 10'd0);
    setFrame(650, 50, 0);
    runFrame(-1, 10'd0);
    setFrame(0, 0, 1);
    runFrame(-1, 10'd0);
    for (int k = 0; k < 2; k++) begin
      setFrame(int'($urandom_range(0, 700)), int'($urandom_range(0, 420)), int'($urandom_range(0, 1)));
      runFrame(int'($urandom_range(0, 200)), 10'($urandom_range(0, 700)));
    end
    for (int i = 0; i < 4; i++) stepPixel(700, 450);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_text_window.md
Name: vga_text_window

Overview:
- Parametrised successor to the single-glyph character handler. Renders a COLS x ROWS window of text at a runtime-programmable origin with runtime magnification 1..4.
- Fetches character codes from an external text buffer and glyph rows from an external font ROM through a fixed 3-stage pipeline.
- Sits between the VGA timing generator (pixelCnt/lineCnt) and the RGB output mux.

Parameters:
- H_ACTIVE, 640, visible pixels per line; pixels at or beyond this are never drawn.
- V_ACTIVE, 400, visible lines per frame.
- GLYPH_W, 8, glyph width in pixels; equals font ROM data width.
- GLYPH_H, 16, glyph height in lines.
- COLS, 8, characters per text row.
- ROWS, 2, text rows.

Ports:
- clock  in  1  pixel clock
- reset  in  1  asynchronous, active-high
- pixelCnt  in  10  current pixel in line
- lineCnt  in  9  current line in frame
- originX  in  10  window left edge in pixels
- originY  in  9  window top edge in lines
- magnify  in  2  scale factor minus 1 (0 gives x1, 3 gives x4)
- fgRGB  in  9  foreground colour {R[2:0],G[2:0],B[2:0]}
- bgRGB  in  9  in-window background colour
- charAddr  out  clog2(COLS*ROWS)  text buffer address, row*COLS+col
- charCode  in  8  text buffer data, valid 1 cycle after charAddr
- fontAddr  out  8+clog2(GLYPH_H)  {charCode, glyphRow}
- fontData  in  GLYPH_W  font row, valid 1 cycle after fontAddr; MSB is leftmost pixel
- inWindow  out  1  registered window-hit flag, aligned with vgaRGB
- vgaRGB  out  9  pixel colour

Behaviour:
- Reset: vgaRGB=0, inWindow=0, charAddr=0, fontAddr=0, all counters=0, shadow origin/magnify=0, armed=0.
- Frame start is the cycle with pixelCnt==0 && lineCnt==0. On that cycle:
  - originX, originY and magnify are copied into shadow registers. Mid-frame input changes have no effect until the next frame start.
  - armed is set to 1.
- While armed=0 (after reset, before the first frame start), vgaRGB and inWindow are held at 0.
- Window size: W = COLS*GLYPH_W*(mag+1), H = ROWS*GLYPH_H*(mag+1).
  - Computed with 12-bit unsigned arithmetic, so there is no overflow.
  - The hit region is clipped to pixelCnt<H_ACTIVE and lineCnt<V_ACTIVE.
- Horizontal counters:
  - When pixelCnt==originX, subX=0, glyphCol=0, charCol=0.
  - On each following in-window pixel, subX increments. When subX wraps at mag, glyphCol increments. When glyphCol wraps at GLYPH_W-1, charCol increments.
  - No divider is used.
- Vertical counters:
  - Update once per line, on the cycle pixelCnt==0.
  - When lineCnt==originY, they clear. Otherwise subY, glyphRow and charRow advance with the same wrap rules, applied to GLYPH_H and ROWS.
- Pipeline:
  - S0: register the hit flag, glyphCol and glyphRow; drive charAddr.
  - S1: charCode arrives; drive fontAddr={charCode,glyphRow}; delay hit and glyphCol.
  - S2: fontData arrives; bit = fontData[GLYPH_W-1-glyphCol].
  - Output register: vgaRGB = hit ? (bit ? fgRGB : bgRGB) : 0, and inWindow = hit.
- Total latency: exactly 3 clocks from pixelCnt to vgaRGB. The timing generator compensates for this.
- Boundaries:
  - A window extending past H_ACTIVE or V_ACTIVE is truncated, not wrapped.
  - originX>=H_ACTIVE gives no hit for the entire frame.
  - Last pixel of the window (charCol=COLS-1, glyphCol=GLYPH_W-1, subX=mag): the next pixel is outside the window and the counters hold.
  - Simultaneous frame start and window start (origin 0,0): the new shadow values apply to that same pixel.
  - Reset mid-frame: the pipeline flushes immediately and output stays 0 until the next frame start.
- fgRGB and bgRGB are sampled at S2, not shadowed.

Optional Feature:
- Macro: VGA_TEXT_CURSOR_EN.
- With the macro defined:
  - Add ports cursorCol (clog2(COLS)), cursorRow (clog2(ROWS)) and cursorOn (1).
  - A 6-bit frame counter increments at each frame start; bit 5 is the blink phase.
  - When cursorOn && phase==1, pixels of the cell (cursorRow,cursorCol) output the inverse of the glyph bit.
  - Cursor inputs are shadowed at frame start.
- Without the macro: no extra ports and no frame counter; behaviour is as above.

Decomposition:
- Shared package vga_pkg:
  - RGB9 typedef.
  - H_ACTIVE and V_ACTIVE defaults.
  - Frame-start predicate constants.
- Sub-module vga_scale_counter, instantiated twice (horizontal and vertical). It implements the sub/glyph/char cascaded counter, with parameters GLYPH_N and CHARS_N and inputs start, advance and mag.

Test Plan:
- Defaults, origin (100,50), magnify=0, buffer cell 0 = 0x41, font row 0 = 8'b1000_0001. At lineCnt=50, fgRGB appears at pixel 100 and at 107, with 3-cycle latency. Pixels 101..106 show bgRGB; pixel 99 and pixel 164 show 0.
- magnify=1, same origin: each font bit spans 2 pixels and 2 lines. Window spans x 100..227 and y 50..113; inWindow=0 at x=228.
- Origin (600,390), magnify=3: output is clipped at pixel 639 and line 399, and no hit occurs on pixel 0 of the next line.
- Change originX from 100 to 200 mid-frame: the current frame still renders at 100; the next frame renders at 200.
- Assert reset at line 60, release at line 70: vgaRGB=0 until the next frame start, then normal rendering resumes.
- Cursor macro defined, cursor at (1,3), cursorOn=1: cell 11 is inverted during frames 32..63 and normal during frames 0..31.
